// File: rtl/vga_line_doubler.sv
// Ping-pong line buffer: captures one source line while replaying the previous
// one across VGA lines, so each source line repeats until the next swap.
module vga_line_doubler #(
  parameter int LINE_PIXELS = 160,
  parameter int H_SHIFT     = 2,
  parameter int H_MAX       = 799
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_valid,
  input  logic [6:0] pix_color,
  input  logic       line_start,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [6:0] color_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       de_out,
  output logic       overrun
);
  localparam int WW = $clog2(LINE_PIXELS + 1);
  localparam int AW = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam logic [WW-1:0] WR_FULL = WW'(LINE_PIXELS);
  localparam logic [9:0]    RD_LAST = 10'(LINE_PIXELS - 1);

  logic [6:0]    r_bank0 [LINE_PIXELS];
  logic [6:0]    r_bank1 [LINE_PIXELS];
  logic [WW-1:0] r_wr_x;
  logic          r_wb;
  logic          r_rb;
  logic          r_cur_rb;
  logic [6:0]    r_rd_data;
  logic          r_de_d1;
  logic          r_hs_d1;
  logic          r_vs_d1;

  logic          w_swap;
  logic          w_wr_en;
  logic          w_drop;
  logic          w_wr_bank;
  logic          w_hend;
  logic          w_clamp;
  logic [AW-1:0] w_wr_addr;
  logic [AW-1:0] w_rd_addr;
  logic [9:0]    w_src_x;
  logic          w_unused_vpos;

  // An empty line (nothing written) never swaps, so the last good line keeps showing.
  assign w_swap    = line_start && (r_wr_x != '0);
  assign w_wr_en   = pix_valid && !reset && (line_start || (r_wr_x < WR_FULL));
  assign w_drop    = pix_valid && !line_start && (r_wr_x == WR_FULL);
  assign w_wr_bank = w_swap ? ~r_wb : r_wb;
  assign w_wr_addr = line_start ? '0 : r_wr_x[AW-1:0];

  assign w_hend    = (hpos == 10'(H_MAX));
  assign w_src_x   = hpos >> H_SHIFT;
  assign w_clamp   = (w_src_x > RD_LAST);
  assign w_rd_addr = w_clamp ? RD_LAST[AW-1:0] : w_src_x[AW-1:0];

  assign w_unused_vpos = ^vpos;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      if (w_wr_bank) begin
        r_bank1[w_wr_addr] <= pix_color;
      end else begin
        r_bank0[w_wr_addr] <= pix_color;
      end
    end
  end

  // cur_rb only reloads at end of VGA line and sees a same-cycle swap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_x   <= '0;
      r_wb     <= 1'b0;
      r_rb     <= 1'b1;
      r_cur_rb <= 1'b1;
      overrun  <= 1'b0;
    end else begin
      if (line_start) begin
        if (w_swap) begin
          r_rb <= r_wb;
          r_wb <= ~r_wb;
        end
        r_wr_x <= pix_valid ? WW'(1) : '0;
      end else if (w_wr_en) begin
        r_wr_x <= r_wr_x + WW'(1);
      end
      if (w_hend) begin
        r_cur_rb <= w_swap ? r_wb : r_rb;
      end
      overrun <= w_drop;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= 7'd0;
      r_de_d1   <= 1'b0;
      r_hs_d1   <= 1'b0;
      r_vs_d1   <= 1'b0;
      color_out <= 7'd0;
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      r_rd_data <= r_cur_rb ? r_bank1[w_rd_addr] : r_bank0[w_rd_addr];
      r_de_d1   <= display_on;
      r_hs_d1   <= hsync_in;
      r_vs_d1   <= vsync_in;
      color_out <= r_de_d1 ? r_rd_data : 7'd0;
      de_out    <= r_de_d1;
      hsync_out <= r_hs_d1;
      vsync_out <= r_vs_d1;
    end
  end
endmodule

// File: tb/tb_vga_line_doubler.sv
// Directed bench for vga_line_doubler: fill, replay, overrun, mid-line swap,
// clamping and reset-during-write, checked against hand-derived pixel patterns.
module tb_vga_line_doubler;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_valid = 1'b0;
  logic [6:0] pix_color = 7'd0;
  logic       line_start = 1'b0;
  logic [9:0] hpos = 10'd0;
  logic [9:0] vpos = 10'd0;
  logic       display_on = 1'b0;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic [6:0] color_out;
  logic       hsync_out;
  logic       vsync_out;
  logic       de_out;
  logic       overrun;

  vga_line_doubler dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_color(pix_color),
    .line_start(line_start), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .color_out(color_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int ovr = 0;
  int wr_cnt = 0;
  int wr_line = 0;
  int ready_line = -1;
  int disp_line = -1;
  bit p_valid = 1'b0;
  bit p_ck = 1'b0;
  logic [6:0] p_col = 7'd0;
  logic p_de = 1'b0, p_hs = 1'b0, p_vs = 1'b0;

  // line 0: x & 0x7F ; line 1: (3x+5) & 0x7F
  function automatic logic [6:0] pat(input int line, input int x);
    logic [6:0] r;
    if (line == 0) r = 7'(x);
    else r = 7'(x * 3 + 5);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input int n, input int line);
    hpos = 10'd0;
    display_on = 1'b0;
    p_valid = 1'b0;
    wr_line = line;
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      pix_color = pat(line, i);
      step();
      if (overrun) ovr++;
    end
    pix_valid = 1'b0;
    step();
    if (overrun) ovr++;
    wr_cnt = (wr_cnt + n > 160) ? 160 : wr_cnt + n;
  endtask

  task automatic pulse_ls();
    p_valid = 1'b0;
    line_start = 1'b1;
    if (wr_cnt > 0) ready_line = wr_line;
    wr_cnt = 0;
    step();
    line_start = 1'b0;
  endtask

  task automatic vga_line(input int swap_at, input bit de_all);
    int xx;
    bit n_ck;
    logic [6:0] n_col;
    vsync_in = ~vsync_in;
    for (int h = 0; h <= 799; h++) begin
      hpos = 10'(h);
      display_on = de_all || (h < 640);
      hsync_in = !(h >= 656 && h < 752);
      line_start = (h == swap_at);
      if (line_start) begin
        if (wr_cnt > 0) ready_line = wr_line;
        wr_cnt = 0;
      end
      xx = h >> 2;
      if (xx > 159) xx = 159;
      n_ck = !display_on || (disp_line >= 0);
      n_col = display_on ? pat(disp_line, xx) : 7'd0;
      if (h == 799) disp_line = ready_line;
      step();
      line_start = 1'b0;
      if (p_valid) begin
        chk("de_out", de_out, p_de);
        chk("hsync_out", hsync_out, p_hs);
        chk("vsync_out", vsync_out, p_vs);
        if (p_ck) chk("color_out", color_out, p_col);
      end
      p_valid = 1'b1;
      p_ck = n_ck;
      p_col = n_col;
      p_de = display_on;
      p_hs = hsync_in;
      p_vs = vsync_in;
    end
  endtask

  initial begin
    step();
    step();
    chk("rst color_out", color_out, 7'd0);
    chk("rst de_out", de_out, 1'b0);
    chk("rst hsync_out", hsync_out, 1'b0);
    chk("rst vsync_out", vsync_out, 1'b0);
    chk("rst overrun", overrun, 1'b0);
    chk("rst wr_x", dut.r_wr_x, 32'd0);
    chk("rst wb", dut.r_wb, 1'b0);
    chk("rst rb", dut.r_rb, 1'b1);
    chk("rst cur_rb", dut.r_cur_rb, 1'b1);
    reset = 1'b0;

    write_px(160, 0);
    chk("fill no overrun", ovr, 32'd0);
    chk("fill wr_x", dut.r_wr_x, 32'd160);
    pulse_ls();
    chk("swap wb", dut.r_wb, 1'b1);
    chk("swap rb", dut.r_rb, 1'b0);
    vga_line(-1, 1'b0);
    chk("cur_rb after line", dut.r_cur_rb, 1'b0);
    vga_line(-1, 1'b0);
    vga_line(-1, 1'b0);
    vga_line(-1, 1'b1);

    ovr = 0;
    write_px(165, 1);
    chk("overrun pulses", ovr, 32'd5);
    chk("overrun wr_x", dut.r_wr_x, 32'd160);
    vga_line(300, 1'b0);
    vga_line(-1, 1'b1);

    write_px(50, 0);
    reset = 1'b1;
    pix_valid = 1'b1;
    line_start = 1'b1;
    hpos = 10'd799;
    step();
    reset = 1'b0;
    pix_valid = 1'b0;
    line_start = 1'b0;
    hpos = 10'd0;
    wr_cnt = 0;
    p_valid = 1'b0;
    chk("mid rst wr_x", dut.r_wr_x, 32'd0);
    chk("mid rst wb", dut.r_wb, 1'b0);
    chk("mid rst cur_rb", dut.r_cur_rb, 1'b1);
    chk("mid rst overrun", overrun, 1'b0);
    chk("mid rst de_out", de_out, 1'b0);
    pulse_ls();
    chk("empty ls wr_x", dut.r_wr_x, 32'd0);
    chk("empty ls rb", dut.r_rb, 1'b1);
    chk("empty ls wb", dut.r_wb, 1'b0);
    chk("empty ls cur_rb", dut.r_cur_rb, 1'b1);
    vga_line(-1, 1'b0);
    chk("final cur_rb", dut.r_cur_rb, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
